// File: rtl/pc_unit.sv
// Program-counter unit: next-PC select (seq/branch/jump/exc/eret/halt), target alignment check.
// Optional return-address stack enabled by defining PC_RAS_EN.
module pc_unit #(
   parameter int                WIDTH        = 32,
   parameter int                INC          = 4,
   parameter int                ALIGN_BITS   = 2,
   parameter logic [WIDTH-1:0]  RESET_VECTOR = '0,
   parameter logic [WIDTH-1:0]  EXC_VECTOR   = WIDTH'(32'h0000_0080),
   parameter int                RAS_DEPTH    = 4
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             LdEn,
   input  logic             BranchTaken,
   input  logic [WIDTH-1:0] BranchTarget,
   input  logic             Jump,
   input  logic [WIDTH-1:0] JumpTarget,
   input  logic             Call,
   input  logic             Ret,
   input  logic             Exc,
   input  logic             Eret,
   input  logic             Halt,
   input  logic             Resume,
   output logic [WIDTH-1:0] Dout,
   output logic [WIDTH-1:0] PcPlus4,
   output logic [WIDTH-1:0] Epc,
   output logic             Valid,
   output logic             Misaligned
);

   typedef enum logic [1:0] {S_BOOT, S_RUN, S_HALT} state_t;

   localparam logic [WIDTH-1:0] L_INC   = WIDTH'(INC);
   localparam logic [WIDTH-1:0] L_AMASK = WIDTH'((64'd1 << ALIGN_BITS) - 64'd1);

   state_t           r_state, w_nxt_state;
   logic [WIDTH-1:0] r_pc, w_nxt_pc;
   logic [WIDTH-1:0] r_epc, w_nxt_epc;
   logic             r_mis, w_nxt_mis;
   logic [WIDTH-1:0] w_pc_plus, w_tgt, w_ras_top;
   logic             w_tgt_mis, w_ras_hit, w_ras_push, w_ras_pop;

   assign w_pc_plus  = r_pc + L_INC;
   assign w_tgt      = Jump ? (w_ras_hit ? w_ras_top : JumpTarget) : BranchTarget;
   assign w_tgt_mis  = |(w_tgt & L_AMASK);

   assign Dout       = r_pc;
   assign PcPlus4    = w_pc_plus;
   assign Epc        = r_epc;
   assign Valid      = (r_state == S_RUN);
   assign Misaligned = r_mis;

   always_comb begin
      w_nxt_state = r_state;
      w_nxt_pc    = r_pc;
      w_nxt_epc   = r_epc;
      w_nxt_mis   = 1'b0;
      w_ras_push  = 1'b0;
      w_ras_pop   = 1'b0;
      case (r_state)
         S_BOOT: w_nxt_state = S_RUN;
         S_RUN: begin
            if (Halt && !Exc) w_nxt_state = S_HALT;
            if (Exc) begin
               w_nxt_epc = r_pc;
               w_nxt_pc  = EXC_VECTOR;
            end else if (Eret) begin
               w_nxt_pc = r_epc;
            end else if (LdEn && !Halt) begin
               if (Jump || BranchTaken) begin
                  // A faulting redirect traps without touching the return stack.
                  if (w_tgt_mis) begin
                     w_nxt_pc  = EXC_VECTOR;
                     w_nxt_epc = r_pc;
                     w_nxt_mis = 1'b1;
                  end else begin
                     w_nxt_pc   = w_tgt;
                     w_ras_push = Jump && Call;
                     w_ras_pop  = w_ras_hit;
                  end
               end else begin
                  w_nxt_pc = w_pc_plus;
               end
            end
         end
         S_HALT: begin
            if (Exc) begin
               w_nxt_epc   = r_pc;
               w_nxt_pc    = EXC_VECTOR;
               w_nxt_state = S_RUN;
            end else if (Resume) begin
               w_nxt_state = S_RUN;
            end
         end
         default: w_nxt_state = S_BOOT;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (!Reset) begin
         r_state <= S_BOOT;
         r_pc    <= RESET_VECTOR;
         r_epc   <= '0;
         r_mis   <= 1'b0;
      end else begin
         r_state <= w_nxt_state;
         r_pc    <= w_nxt_pc;
         r_epc   <= w_nxt_epc;
         r_mis   <= w_nxt_mis;
      end
   end

`ifdef PC_RAS_EN
   localparam int             L_PW   = $clog2(RAS_DEPTH);
   localparam logic [L_PW:0]  L_FULL = (L_PW+1)'(RAS_DEPTH);

   logic [WIDTH-1:0] r_ras [RAS_DEPTH];
   logic [L_PW-1:0]  r_ras_ptr, w_top_idx;
   logic [L_PW:0]    r_ras_cnt;

   assign w_top_idx = r_ras_ptr - L_PW'(1);
   assign w_ras_top = r_ras[w_top_idx];
   assign w_ras_hit = Jump && Ret && (r_ras_cnt != '0);

   // Pointer marks the next free slot; when full it also marks the oldest entry.
   always_ff @(posedge Clk) begin
      if (!Reset) begin
         r_ras_ptr <= '0;
         r_ras_cnt <= '0;
      end else if (w_ras_push && !w_ras_pop) begin
         r_ras_ptr <= r_ras_ptr + L_PW'(1);
         if (r_ras_cnt != L_FULL) r_ras_cnt <= r_ras_cnt + 1'b1;
      end else if (w_ras_pop && !w_ras_push) begin
         r_ras_ptr <= w_top_idx;
         r_ras_cnt <= r_ras_cnt - 1'b1;
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset && w_ras_push) begin
         if (w_ras_pop) r_ras[w_top_idx] <= w_pc_plus;
         else           r_ras[r_ras_ptr] <= w_pc_plus;
      end
   end
`else
   logic w_unused_ras;
   assign w_ras_hit    = 1'b0;
   assign w_ras_top    = '0;
   assign w_unused_ras = &{1'b0, Call, Ret, w_ras_push, w_ras_pop};
`endif

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised program-counter unit; successor to the plain loadable PC register.
- Owns next-PC selection: sequential increment, branch, jump, exception entry/return, halt/resume.
- Checks target alignment.
- Sits at the head of the fetch stage.
- Dout drives instruction-memory address; PcPlus4 feeds link-register writeback and branch adders.

Parameters:
WIDTH, 32, PC and address width in bits
INC, 4, sequential increment in bytes
ALIGN_BITS, 2, low target bits that must be zero
RESET_VECTOR, 0, PC value loaded at reset
EXC_VECTOR, 32'h0000_0080, PC value loaded on exception or misalignment
RAS_DEPTH, 4, return-address-stack entries (only with PC_RAS_EN); power of two, >=2

Ports:
Clk  in  1  clock, all state updates on rising edge
Reset  in  1  synchronous, active-low reset
LdEn  in  1  advance enable; 0 = stall (sequential, branch and jump loads blocked)
BranchTaken  in  1  load BranchTarget
BranchTarget  in  WIDTH  branch destination
Jump  in  1  load JumpTarget
JumpTarget  in  WIDTH  jump destination
Call  in  1  qualifies Jump as call (RAS push); ignored without PC_RAS_EN
Ret  in  1  qualifies Jump as return (RAS pop); ignored without PC_RAS_EN
Exc  in  1  exception request
Eret  in  1  return from exception
Halt  in  1  enter HALT
Resume  in  1  leave HALT
Dout  out  WIDTH  current PC
PcPlus4  out  WIDTH  Dout + INC (combinational, modulo 2^WIDTH)
Epc  out  WIDTH  saved exception PC
Valid  out  1  Dout is a fetchable PC this cycle
Misaligned  out  1  one-cycle pulse: a selected target failed alignment

Behaviour:
- Reset (Reset=0 at rising edge): Dout=RESET_VECTOR, Epc=0, Misaligned=0, state=BOOT, RAS empty. Reset overrides every other input, including mid-halt and mid-exception.
- States:
  - BOOT: Valid=0, Dout held. Next edge -> RUN, regardless of other inputs.
  - RUN: Valid=1. Halt=1 (with no Exc) -> HALT, Dout held.
  - HALT: Valid=0, Dout held. Resume=1 -> RUN, Dout unchanged. Exc=1 in HALT: exception entry and -> RUN.
- Next-PC priority in RUN, highest first:
  1. Exc: Epc<=Dout, Dout<=EXC_VECTOR. Ignores LdEn.
  2. Eret: Dout<=Epc. Ignores LdEn.
  3. Halt: hold.
  4. LdEn=0: hold.
  5. Jump: Dout<=JumpTarget (or RAS top, see feature).
  6. BranchTaken: Dout<=BranchTarget.
  7. Otherwise: Dout<=PcPlus4.
- Alignment check on cases 5 and 6 only (target[ALIGN_BITS-1:0]!=0):
  - Dout<=EXC_VECTOR, Epc<=Dout (faulting instruction's PC).
  - Misaligned=1 for exactly one cycle.
  - Eret target and PcPlus4 are not checked.
- ALIGN_BITS=0 disables the check.
- Wrap-around: increment from 2^WIDTH-INC yields 0, no flag.
- Single-cycle latency: a redirect sampled at edge N appears on Dout after edge N.
- Simultaneous Jump+BranchTaken: Jump wins. Exc+Eret: Exc wins.

Optional Feature:
- Macro PC_RAS_EN.
- Defined:
  - Circular return-address stack of RAS_DEPTH WIDTH-bit entries plus occupancy counter.
  - Jump&Call (advancing in RUN with LdEn=1): push PcPlus4. When full, overwrite oldest; count saturates at RAS_DEPTH.
  - Jump&Ret with stack non-empty: target = top entry; pop.
  - Jump&Ret with stack empty: target = JumpTarget.
  - Call&Ret together: pop then push (net count unchanged), target = popped top.
  - RAS targets undergo the alignment check.
  - Exc, Halt and stall do not modify the RAS.
- Undefined: no RAS storage; Call and Ret ignored; Jump always uses JumpTarget.

Test Plan:
- Reset=0 two cycles, release, LdEn=1 -> cycle 1 Dout=0, Valid=0 (BOOT); then 0,4,8,12 with Valid=1.
- At Dout=0x10 pulse LdEn=0 three cycles, then Jump=1 with JumpTarget=0x40 and BranchTaken=1 with BranchTarget=0x80 -> Dout holds 0x10 while stalled; next is 0x40.
- At Dout=0x20, BranchTarget=0x22 -> Dout=0x80, Epc=0x20, Misaligned=1 for one cycle; then Eret=1 -> Dout=0x20.
- At Dout=0x30 assert Halt -> Valid=0, Dout=0x30 held; Exc=1 -> Dout=0x80, Epc=0x30, state RUN; Reset=0 mid-halt -> Dout=0, BOOT.
- WIDTH=8, INC=4, RESET_VECTOR=8'hF8 -> Dout sequence F8, FC, 00, 04.
- PC_RAS_EN, RAS_DEPTH=4:
  - Five calls from 0x0, 0x10, 0x20, 0x30, 0x40 -> five returns yield 0x44, 0x34, 0x24, 0x14.
  - Fifth return uses JumpTarget.
